// File: rtl/remap_ctrl_pkg.sv
// Shared state and error-index definitions for the remapper frame sequencer.
package remap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    FLUSH
  } ctrl_state_t;

  localparam int ERR_SOF_ABORT = 2;
  localparam int ERR_EOL       = 1;
  localparam int ERR_CFG       = 0;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry valid/ready register slice; output is fully registered.
module axis_reg_slice #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/remap_frame_ctrl.sv
// Frame sequencer in front of the 12k remapper: admits, reframes and pads frames.
// Optional REMAP_FRAME_STATS_EN adds completed/dropped frame counters.
module remap_frame_ctrl
  import remap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int DIM_WIDTH        = 16,
  parameter int IMAGE_KERNEL_12K = 64
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_enable,
  input  logic [DIM_WIDTH-1:0]  WIDTH,
  input  logic [DIM_WIDTH-1:0]  HEIGHT,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [2:0]            o_err
`ifdef REMAP_FRAME_STATS_EN
  ,
  output logic [31:0]           o_frame_cnt,
  output logic [31:0]           o_drop_cnt
`endif
);

  localparam logic [DIM_WIDTH-1:0] KERN = DIM_WIDTH'(IMAGE_KERNEL_12K);
  localparam int PW = DATA_WIDTH + 2;

  ctrl_state_t          r_state;
  ctrl_state_t          w_next;
  logic [DIM_WIDTH-1:0] r_x;
  logic [DIM_WIDTH-1:0] r_y;
  logic [DIM_WIDTH-1:0] r_wm1;
  logic [DIM_WIDTH-1:0] r_hm1;
  logic                 r_last_pend;
  logic [2:0]           r_err;

  logic                  w_cfg_ok;
  logic                  w_x_end;
  logic                  w_y_end;
  logic                  w_mid;
  logic                  w_slice_rdy;
  logic                  w_s_rdy;
  logic                  w_in_valid;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic                  w_in_user;
  logic                  w_in_last;
  logic                  w_start;
  logic                  w_adv;
  logic                  w_end;
  logic                  w_e_abort;
  logic                  w_e_eol;
  logic                  w_e_cfg;
  logic                  w_leave;
  logic [PW-1:0]         w_m_pay;

  assign w_cfg_ok = (WIDTH != '0) && ((WIDTH % KERN) == '0) &&
                    (HEIGHT != '0);
  assign w_x_end  = (r_x == r_wm1);
  assign w_y_end  = (r_y == r_hm1);
  assign w_mid    = (r_x != '0) || (r_y != '0);

  always_comb begin
    w_next     = r_state;
    w_s_rdy    = 1'b0;
    w_in_valid = 1'b0;
    w_in_data  = '0;
    w_in_user  = 1'b0;
    w_in_last  = 1'b0;
    w_start    = 1'b0;
    w_adv      = 1'b0;
    w_end      = 1'b0;
    w_e_abort  = 1'b0;
    w_e_eol    = 1'b0;
    w_e_cfg    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_s_rdy = w_slice_rdy;
        if (s_axis_tvalid && w_slice_rdy && s_axis_tuser) begin
          if (i_enable && w_cfg_ok) begin
            w_in_valid = 1'b1;
            w_in_data  = s_axis_tdata;
            w_in_user  = 1'b1;
            w_start    = 1'b1;
            w_e_eol    = s_axis_tlast;
            w_next     = PASS;
          end else if (i_enable) begin
            w_e_cfg = 1'b1;
          end
        end
      end
      PASS: begin
        // A mid-frame SOF is held off; the frame is padded out first.
        if (s_axis_tvalid && s_axis_tuser && w_mid) begin
          w_e_abort = 1'b1;
          w_next    = FLUSH;
        end else begin
          w_s_rdy = w_slice_rdy;
          if (s_axis_tvalid && w_slice_rdy) begin
            w_in_valid = 1'b1;
            w_in_data  = s_axis_tdata;
            w_in_last  = w_x_end;
            w_adv      = 1'b1;
            w_e_eol    = (s_axis_tlast != w_x_end);
            if (w_x_end && w_y_end) begin
              w_end  = 1'b1;
              w_next = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        w_in_valid = 1'b1;
        w_in_last  = w_x_end;
        if (w_slice_rdy) begin
          w_adv = 1'b1;
          if (w_x_end && w_y_end) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_wm1   <= '0;
      r_hm1   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_x   <= DIM_WIDTH'(1);
        r_y   <= '0;
        r_wm1 <= WIDTH - 1'b1;
        r_hm1 <= HEIGHT - 1'b1;
      end else if (w_adv) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign w_leave = m_axis_tvalid & m_axis_tready;

  // Marks that the beat sitting in the slice closes a completed frame.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_last_pend <= 1'b0;
      r_err       <= '0;
    end else begin
      if (w_end) r_last_pend <= 1'b1;
      else if (w_leave) r_last_pend <= 1'b0;
      r_err[ERR_SOF_ABORT] <= w_e_abort;
      r_err[ERR_EOL]       <= w_e_eol;
      r_err[ERR_CFG]       <= w_e_cfg;
    end
  end

  axis_reg_slice #(.W(PW)) u_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_aresetn),
    .i_valid (w_in_valid),
    .o_ready (w_slice_rdy),
    .i_data  ({w_in_user, w_in_last, w_in_data}),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_data  (w_m_pay)
  );

  assign m_axis_tuser  = w_m_pay[PW-1];
  assign m_axis_tlast  = w_m_pay[PW-2];
  assign m_axis_tdata  = w_m_pay[DATA_WIDTH-1:0];
  assign s_axis_tready = w_s_rdy & i_aresetn;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_done  = w_leave & r_last_pend;
  assign o_err         = r_err;

`ifdef REMAP_FRAME_STATS_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (o_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_e_abort || w_e_cfg) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
`endif

endmodule
